// File: rtl/combo_entry_checker_if.sv
// ---------------------------------------------------------------------------
// combo_entry_checker_if
// Bundles the digit-entry inputs and lock status outputs of the combo lock
// checker so the checker and whatever drives it share one connection.
//
// Signals:
//   digit       entered digit value from the switches (DIGIT_W bits)
//   enter       raw enter button, asynchronous, active-high
//   clear       synchronous abort / relock request, active-high
//   digit_idx   digits captured so far in the current attempt (0..3)
//   unlocked    high while the lock is open
//   error       one-clock pulse on a failed attempt
//   locked_out  high while the lockout timer runs
//   fail_count  consecutive failed attempts so far
//
// Modports:
//   master  the side that drives digit/enter/clear and watches the status
//   slave   the checker itself
// ---------------------------------------------------------------------------
interface combo_entry_checker_if #(
    parameter int DIGIT_W = 4
);
    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               clear;
    logic [1:0]         digit_idx;
    logic               unlocked;
    logic               error;
    logic               locked_out;
    logic [2:0]         fail_count;

    modport master (
        output digit, enter, clear,
        input  digit_idx, unlocked, error, locked_out, fail_count
    );

    modport slave (
        input  digit, enter, clear,
        output digit_idx, unlocked, error, locked_out, fail_count
    );
endinterface

// File: rtl/combo_entry_checker.sv
// ---------------------------------------------------------------------------
// combo_entry_checker
// Consumer stage of the combo lock digit-entry path. Synchronizes the enter
// button, captures one digit per press into a 4-digit attempt, compares the
// attempt against CODE and runs the lock's top-level state machine
// (ENTRY, CHECK, OPEN, FAIL and optionally LOCKOUT).
//
// Ports:
//   clk   system clock, everything on posedge
//   rst   synchronous, active-low reset
//   bus   combo_entry_checker_if.slave: digit/enter/clear in,
//         digit_idx/unlocked/error/locked_out/fail_count out
//
// Build option:
//   COMBO_LOCK_LOCKOUT_EN  when defined, consecutive failures are counted
//                          and MAX_FAILS of them lock the keypad out for
//                          LOCKOUT_CYCLES clocks. When undefined there is no
//                          fail counter and fail_count/locked_out read 0.
// ---------------------------------------------------------------------------
module combo_entry_checker #(
    parameter int                   DIGIT_W        = 4,
    parameter logic [4*DIGIT_W-1:0] CODE           = 16'h1234,
    parameter int                   UNLOCK_CYCLES  = 50_000_000,
    parameter int                   MAX_FAILS      = 3,
    parameter int                   LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    combo_entry_checker_if.slave  bus
);

    // One timer serves both OPEN and LOCKOUT, so it is sized for the longer.
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } state_t;

    state_t                 state, state_n;
    logic                   sync1, sync2, enter_prev, press;
    logic [4*DIGIT_W-1:0]   entry, entry_n;
    logic [1:0]             idx, idx_n;
    logic [TW-1:0]          timer, timer_n;
    logic                   unlocked_q, error_q;

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);

    logic [2:0]             fails, fails_n;
    logic                   locked_q;
`endif

    // Two-flop synchronizer on the raw button followed by a registered
    // rising-edge detect, so a held button produces a single press pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            enter_prev <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync1      <= bus.enter;
            sync2      <= sync1;
            enter_prev <= sync2;
            press      <= sync2 & ~enter_prev;
        end
    end

    // Next-state and datapath updates for the lock state machine.
    always_comb begin
        state_n = state;
        entry_n = entry;
        idx_n   = idx;
        timer_n = timer;
`ifdef COMBO_LOCK_LOCKOUT_EN
        fails_n = fails;
`endif
        case (state)
            ENTRY: begin
                // clear outranks a press landing in the same cycle.
                if (bus.clear) begin
                    entry_n = '0;
                    idx_n   = '0;
                end else if (press) begin
                    // Slot 0 lives in the most significant digit of the entry.
                    entry_n[(3 - int'(idx)) * DIGIT_W +: DIGIT_W] = bus.digit;
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_n = CHECK;
                    end
                end
            end

            CHECK: begin
                entry_n = '0;
                if (entry == CODE) begin
                    state_n = OPEN;
                    timer_n = TW'(UNLOCK_CYCLES - 1);
`ifdef COMBO_LOCK_LOCKOUT_EN
                    fails_n = '0;
`endif
                end else begin
`ifdef COMBO_LOCK_LOCKOUT_EN
                    fails_n = (fails == 3'd7) ? 3'd7 : fails + 3'd1;
                    if (fails_n == FAIL_LIMIT) begin
                        state_n = LOCKOUT;
                        timer_n = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_n = FAIL;
                    end
`else
                    state_n = FAIL;
`endif
                end
            end

            OPEN: begin
                // Timer was loaded with N-1 so the state lasts N clocks.
                if (bus.clear || timer == '0) begin
                    state_n = ENTRY;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end

            FAIL: begin
                state_n = ENTRY;
                entry_n = '0;
                idx_n   = '0;
            end

`ifdef COMBO_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (timer == '0) begin
                    state_n = ENTRY;
                    fails_n = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`endif

            default: begin
                state_n = ENTRY;
            end
        endcase
    end

    // State, entry and timer registers; status outputs are registered from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ENTRY;
            entry      <= '0;
            idx        <= '0;
            timer      <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
`ifdef COMBO_LOCK_LOCKOUT_EN
            fails      <= '0;
            locked_q   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            entry      <= entry_n;
            idx        <= idx_n;
            timer      <= timer_n;
            unlocked_q <= (state_n == OPEN);
            error_q    <= (state_n == FAIL);
`ifdef COMBO_LOCK_LOCKOUT_EN
            fails      <= fails_n;
            locked_q   <= (state_n == LOCKOUT);
`endif
        end
    end

    assign bus.digit_idx = idx;
    assign bus.unlocked  = unlocked_q;
    assign bus.error     = error_q;
`ifdef COMBO_LOCK_LOCKOUT_EN
    assign bus.locked_out = locked_q;
    assign bus.fail_count = fails;
`else
    assign bus.locked_out = 1'b0;
    assign bus.fail_count = 3'd0;
`endif

endmodule

// File: tb/tb_combo_entry_checker.sv
// ---------------------------------------------------------------------------
// tb_combo_entry_checker
// Self-checking bench for combo_entry_checker with UNLOCK_CYCLES=8,
// LOCKOUT_CYCLES=16, MAX_FAILS=3. A behavioural model tracks the attempt as
// a queue of digits plus a phase and a cycles-remaining count; a compare
// process checks every output against it each cycle. Directed scenarios pin
// the model with literal expectations, then randomized presses, clears and
// resets run against the model. Honours COMBO_LOCK_LOCKOUT_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_combo_entry_checker;

    localparam int          DIGIT_W = 4;
    localparam logic [15:0] CODE    = 16'h1234;
    localparam int          UC      = 8;
    localparam int          MF      = 3;
    localparam int          LC      = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    combo_entry_checker_if #(.DIGIT_W(DIGIT_W)) bus();

    combo_entry_checker #(
        .DIGIT_W        (DIGIT_W),
        .CODE           (CODE),
        .UNLOCK_CYCLES  (UC),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int fail_prints = 0;

    // Behavioural model state.
    typedef enum int {P_ENTRY, P_CHECK, P_OPEN, P_FAIL, P_LOCK} phase_t;
    phase_t     m_phase  = P_ENTRY;
    int         m_remain = 0;
    int         m_fails  = 0;
    logic [3:0] m_digits[$];
    bit         m_hist[4] = '{0, 0, 0, 0};
    logic [1:0] e_idx = 2'd0;
    logic       e_unl = 1'b0, e_err = 1'b0, e_lck = 1'b0;
    logic [2:0] e_fc  = 3'd0;

    // A press becomes usable three edges after the button is first seen high.
    always @(posedge clk) begin
        bit p;
        logic [15:0] attempt;
        if (!rst) begin
            m_hist   = '{0, 0, 0, 0};
            m_phase  = P_ENTRY;
            m_remain = 0;
            m_fails  = 0;
            m_digits.delete();
        end else begin
            p = m_hist[2] && !m_hist[3];
            m_hist[3] = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = bus.enter;
            case (m_phase)
                P_ENTRY: begin
                    if (bus.clear) m_digits.delete();
                    else if (p) begin
                        m_digits.push_back(bus.digit);
                        if (m_digits.size() == 4) m_phase = P_CHECK;
                    end
                end
                P_CHECK: begin
                    attempt = {m_digits[0], m_digits[1], m_digits[2], m_digits[3]};
                    m_digits.delete();
                    if (attempt == CODE) begin
                        m_phase  = P_OPEN;
                        m_remain = UC;
                        m_fails  = 0;
                    end else begin
`ifdef COMBO_LOCK_LOCKOUT_EN
                        m_fails = (m_fails < 7) ? m_fails + 1 : 7;
                        if (m_fails == MF) begin
                            m_phase  = P_LOCK;
                            m_remain = LC;
                        end else m_phase = P_FAIL;
`else
                        m_phase = P_FAIL;
`endif
                    end
                end
                P_OPEN: begin
                    m_remain--;
                    if (bus.clear || m_remain == 0) m_phase = P_ENTRY;
                end
                P_FAIL: m_phase = P_ENTRY;
                P_LOCK: begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_phase = P_ENTRY;
                        m_fails = 0;
                    end
                end
                default: m_phase = P_ENTRY;
            endcase
        end
        e_idx = 2'(m_digits.size() % 4);
        e_unl = (m_phase == P_OPEN);
        e_err = (m_phase == P_FAIL);
        e_lck = (m_phase == P_LOCK);
        e_fc  = 3'(m_fails);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.digit_idx !== e_idx || bus.unlocked !== e_unl || bus.error !== e_err ||
                bus.locked_out !== e_lck || bus.fail_count !== e_fc) begin
                bad++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("[TB] FAIL cycle t=%0t: got idx=%0d unl=%0b err=%0b lck=%0b fc=%0d want idx=%0d unl=%0b err=%0b lck=%0b fc=%0d",
                             $time, bus.digit_idx, bus.unlocked, bus.error, bus.locked_out, bus.fail_count,
                             e_idx, e_unl, e_err, e_lck, e_fc);
                end
            end
        end
    end

    // Event counters used by the directed scenarios.
    int cyc = 0, unl_first = -1, unl_cnt = 0, err_cnt = 0, lck_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (bus.unlocked === 1'b1) begin
            unl_cnt++;
            if (unl_first < 0) unl_first = cyc;
        end
        if (bus.error === 1'b1) err_cnt++;
        if (bus.locked_out === 1'b1) lck_cnt++;
    end

    task automatic clearCounts();
        #1;
        cyc = 0; unl_first = -1; unl_cnt = 0; err_cnt = 0; lck_cnt = 0;
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One button press: enter high for 'hold' cycles then low for 'gap';
    // with clr set, clear is raised on the cycle the press gets captured.
    task automatic applyStimulus(input logic [3:0] d, input int hold, input int gap, input bit clr);
        for (int i = 0; i <= hold + gap; i++) begin
            @(negedge clk);
            if (i == 0) bus.digit = d;
            bus.enter = (i < hold);
            bus.clear = clr && (i == 3);
        end
        bus.clear = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int k = 0; k < 4; k++) applyStimulus(v[15 - 4*k -: 4], 1, 3, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.digit = '0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset idx", int'(bus.digit_idx), 0);
        checkOutput("reset unlocked", int'(bus.unlocked), 0);
        checkOutput("reset error", int'(bus.error), 0);
        checkOutput("reset locked_out", int'(bus.locked_out), 0);
        checkOutput("reset fail_count", int'(bus.fail_count), 0);
        rst = 1'b1;
        idle(2);

        // Reset in the middle of an attempt, then a correct code.
        applyStimulus(4'd1, 1, 3, 1'b0);
        applyStimulus(4'd2, 1, 3, 1'b0);
        checkOutput("two digits idx", int'(bus.digit_idx), 2);
        doReset(2);
        checkOutput("midreset idx", int'(bus.digit_idx), 0);
        checkOutput("midreset unlocked", int'(bus.unlocked), 0);
        enterCode(16'h1234);
        clearCounts();
        idle(20);
        checkOutput("unlock rise", unl_first, 1);
        checkOutput("unlock width", unl_cnt, UC);
        checkOutput("unlock fail_count", int'(bus.fail_count), 0);
        checkOutput("unlock dropped", int'(bus.unlocked), 0);

        // Single wrong attempt.
        clearCounts();
        enterCode(16'h1235);
        idle(5);
        checkOutput("wrong error pulses", err_cnt, 1);
`ifdef COMBO_LOCK_LOCKOUT_EN
        checkOutput("wrong fail_count", int'(bus.fail_count), 1);
`else
        checkOutput("wrong fail_count", int'(bus.fail_count), 0);
`endif
        checkOutput("wrong idx", int'(bus.digit_idx), 0);

        // Repeated wrong attempts from a fresh reset.
        doReset(1);
        clearCounts();
`ifdef COMBO_LOCK_LOCKOUT_EN
        enterCode(16'h9999);
        enterCode(16'h4321);
        enterCode(16'h1230);
        applyStimulus(4'd9, 1, 3, 1'b0);
        checkOutput("lockout press idx", int'(bus.digit_idx), 0);
        checkOutput("lockout active", int'(bus.locked_out), 1);
        idle(25);
        checkOutput("lockout errors", err_cnt, MF - 1);
        checkOutput("lockout width", lck_cnt, LC);
        checkOutput("lockout fail_count", int'(bus.fail_count), 0);
`else
        for (int k = 0; k < 4; k++) enterCode(16'h1111 * (k + 5));
        idle(5);
        checkOutput("nolock errors", err_cnt, 4);
        checkOutput("nolock locked_out", lck_cnt, 0);
`endif

        // Clear arriving on the same cycle as a press.
        applyStimulus(4'd1, 1, 3, 1'b0);
        applyStimulus(4'd2, 1, 3, 1'b1);
        checkOutput("clear idx", int'(bus.digit_idx), 0);
        clearCounts();
        enterCode(16'h1234);
        idle(20);
        checkOutput("clear then unlock", unl_cnt, UC);

        // Held button captures exactly once.
        applyStimulus(4'd7, 20, 3, 1'b0);
        checkOutput("held idx", int'(bus.digit_idx), 1);
        @(negedge clk); bus.clear = 1'b1;
        @(negedge clk); bus.clear = 1'b0;
        checkOutput("held clear idx", int'(bus.digit_idx), 0);

        // Randomized traffic, mostly correct digits so unlocks happen.
        for (int n = 0; n < 400; n++) begin
            int act;
            logic [15:0] cv;
            logic [3:0] d;
            act = int'($urandom_range(0, 99));
            cv = CODE;
            if (act < 70) begin
                d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : cv[15 - 4*int'(e_idx) -: 4];
                applyStimulus(d, int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                              ($urandom_range(0, 9) == 0));
            end else if (act < 80) begin
                @(negedge clk); bus.clear = 1'b1;
                @(negedge clk); bus.clear = 1'b0;
            end else if (act < 98) begin
                idle(int'($urandom_range(1, 12)));
            end else begin
                doReset(int'($urandom_range(1, 2)));
            end
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combo_entry_checker.md
Name: combo_entry_checker

Overview:
- Downstream consumer stage of the digit-entry path in the FPGA combo lock.
- Samples a 4-bit digit from the switches on each enter-button press and assembles a 4-digit attempt.
- Compares the attempt against the stored code and drives the unlock, error and lockout indications.
- Owns the lock's top-level state machine; the digit counter and LEDs hang off its outputs.

Parameters:
- DIGIT_W, 4, width of one entered digit.
- CODE, 16'h1234, stored combination; digit 0 is CODE[15:12], digit 3 is CODE[3:0].
- UNLOCK_CYCLES, 50_000_000, clocks the unlocked output is held.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..7).
- LOCKOUT_CYCLES, 250_000_000, clocks lockout lasts.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- digit  input  DIGIT_W  switch value sampled on a press.
- enter  input  1  raw enter button, asynchronous, active-high.
- clear  input  1  synchronous, active-high; abort entry or relock.
- digit_idx  output  2  number of digits captured in the current attempt (0..3).
- unlocked  output  1  high while in OPEN.
- error  output  1  one-clock pulse on a failed attempt.
- locked_out  output  1  high while in LOCKOUT.
- fail_count  output  3  consecutive failures so far.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to ENTRY.
  - digit_idx=0, unlocked=0, error=0, locked_out=0, fail_count=0.
  - Entry register cleared to 0; synchronizer flops cleared to 0.
  - Reset is honoured in any state, mid-attempt included.
- Press detection:
  - enter passes through a 2-flop synchronizer, then a registered rising-edge detect giving a one-clock press pulse.
  - Press pulse is asserted the 3rd posedge after enter rises.
  - Holding enter yields exactly one press.
- States: ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- ENTRY:
  - On press, digit is stored in slot digit_idx and digit_idx increments.
  - A press with digit_idx==3 stores the last digit, wraps digit_idx to 0, and moves to CHECK on the next clock.
  - clear: entry register and digit_idx are zeroed; state stays ENTRY.
  - clear and press in the same cycle: clear wins and the digit is discarded.
- CHECK (exactly one clock):
  - Full 16-bit compare against CODE.
  - Match: go to OPEN; fail_count goes to 0.
  - Mismatch: fail_count increments (saturating at 7).
  - If the incremented value equals MAX_FAILS, go to LOCKOUT; otherwise go to FAIL.
- FAIL (one clock): error=1 for this cycle only, then return to ENTRY with the entry register zeroed.
- OPEN:
  - unlocked=1 while a down-counter runs UNLOCK_CYCLES clocks, then return to ENTRY.
  - clear returns to ENTRY on the next clock.
  - Presses are ignored.
- LOCKOUT:
  - locked_out=1 for LOCKOUT_CYCLES clocks.
  - Presses and clear are ignored.
  - On exit, fail_count goes to 0 and state returns to ENTRY.
- Timer:
  - One shared down-counter, sized to $clog2 of the larger of UNLOCK_CYCLES and LOCKOUT_CYCLES.
  - Loaded on entry to OPEN or LOCKOUT.
  - State exits on the clock where the counter reads 0.
- Outputs are registered except digit_idx, which is the index register itself.

Optional Feature:
- COMBO_LOCK_LOCKOUT_EN defined:
  - LOCKOUT state, fail counter and lockout behaviour exist as described above.
- COMBO_LOCK_LOCKOUT_EN undefined:
  - No LOCKOUT state and no fail counter.
  - fail_count and locked_out are tied to 0.
  - Every mismatch goes CHECK -> FAIL -> ENTRY.
  - MAX_FAILS and LOCKOUT_CYCLES are unused.

Test Plan (bench overrides UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, MAX_FAILS=3):
- Hold rst=0 for 2 clocks mid-entry after 2 digits -> digit_idx=0, all outputs 0, state ENTRY; a following correct 1,2,3,4 sequence unlocks.
- Press with digits 1,2,3,4 -> unlocked rises 2 clocks after the 4th press pulse (CHECK then OPEN), stays high 8 clocks, drops; fail_count=0.
- Press with digits 1,2,3,5 -> a single-cycle error pulse; fail_count=1; digit_idx=0.
- Make three wrong attempts -> 3rd attempt gives no error pulse; locked_out=1 for 16 clocks; presses during lockout leave digit_idx=0; afterwards fail_count=0.
- Press digit 1, then digit 2 with clear asserted in the same cycle as the press -> digit_idx=0; a subsequent 1,2,3,4 unlocks.
- Hold enter high for 20 clocks with digit=7 -> exactly one capture, digit_idx=1; with the macro undefined, four wrong attempts -> four error pulses and locked_out stays 0.
